// File: rtl/i2s_pkg.sv
// ---------------------------------------------------------------------------
// i2s_pkg
// Shared types and constants for the I2S receiver and transmitter.
//   i2s_rx_state_t : receive framing states
//   I2S_DATA_W_DEF : default channel word width
//   WAVE_OFFSET    : XOR mask turning a two's-complement byte into offset binary
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
package i2s_pkg;

  typedef enum logic [1:0] {
    WAIT_SYNC = 2'd0,
    DELAY     = 2'd1,
    SHIFT     = 2'd2
  } i2s_rx_state_t;

  localparam int         I2S_DATA_W_DEF = 16;
  localparam logic [7:0] WAVE_OFFSET    = 8'h80;

endpackage

// File: rtl/i2s_sync_edge.sv
// ---------------------------------------------------------------------------
// i2s_sync_edge
// STAGES-deep synchronizer for one asynchronous pin, followed by a delayed
// copy of the last stage and registered single-cycle edge pulses.
// An edge on pin_i shows up on rise_o/fall_o STAGES+1 clk cycles later.
// Ports:
//   clk, rst_n : system clock, async active-low reset
//   pin_i      : asynchronous input pin
//   rise_o     : one-cycle pulse on a synchronized rising edge
//   fall_o     : one-cycle pulse on a synchronized falling edge
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module i2s_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin_i,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              dly_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      dly_q  <= 1'b0;
      rise_o <= 1'b0;
      fall_o <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], pin_i};
      dly_q  <= sync_q[STAGES-1];
      rise_o <= sync_q[STAGES-1] & ~dly_q;
      fall_o <= ~sync_q[STAGES-1] & dly_q;
    end
  end

endmodule

// File: rtl/i2s_receiver.sv
// ---------------------------------------------------------------------------
// i2s_receiver
// Oversampling I2S receiver: frames left/right words from ADCDAT, publishes
// each pair with a valid/ready handshake and an offset-binary display byte.
// Optional feature macro: I2S_RX_FRAME_CHECK_EN enables short-channel
// detection on frame_err; without it frame_err is tied to 0.
// Ports:
//   clk, rst_n          : 50 MHz system clock, async active-low reset
//   bclk_in, lrck_in    : I2S bit clock / word clock (async to clk)
//   dat_in              : serial data, sampled on rising bclk
//   sample_l, sample_r  : last completed left/right words
//   wave_out            : sample_l MSB byte in offset binary
//   sample_valid        : pair held on outputs
//   sample_ready        : consumer accepts pair
//   overrun             : sticky, a pair was overwritten before acceptance
//   frame_err           : published pair had a short channel
//
// state     | meaning
// ----------+------------------------------------------------------------
// WAIT_SYNC | after reset, ignore everything until first lrck falling edge
// DELAY     | skip the one-bit I2S slot after an lrck edge
// SHIFT     | shift data bits until the next lrck edge closes the channel
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module i2s_receiver
  import i2s_pkg::*;
#(
  parameter int DATA_W      = I2S_DATA_W_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              bclk_in,
  input  logic              lrck_in,
  input  logic              dat_in,
  output logic [DATA_W-1:0] sample_l,
  output logic [DATA_W-1:0] sample_r,
  output logic [7:0]        wave_out,
  output logic              sample_valid,
  input  logic              sample_ready,
  output logic              overrun,
  output logic              frame_err
);

  localparam int              CNT_W    = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] DATA_W_C = CNT_W'(DATA_W);

  logic bclk_rise;
  logic unused_bclk_fall;
  logic lrck_rise;
  logic lrck_fall;
  logic lrck_edge;

  i2s_sync_edge #(.STAGES(SYNC_STAGES)) u_bclk_edge (
    .clk    (clk),
    .rst_n  (rst_n),
    .pin_i  (bclk_in),
    .rise_o (bclk_rise),
    .fall_o (unused_bclk_fall)
  );

  i2s_sync_edge #(.STAGES(SYNC_STAGES)) u_lrck_edge (
    .clk    (clk),
    .rst_n  (rst_n),
    .pin_i  (lrck_in),
    .rise_o (lrck_rise),
    .fall_o (lrck_fall)
  );

  assign lrck_edge = lrck_rise | lrck_fall;

  // Data gets the plain synchronizer; the one-cycle lag of the registered
  // bclk pulse is harmless since dat is stable for a full bclk period.
  logic [SYNC_STAGES-1:0] dat_sync_q;
  logic                   dat_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dat_sync_q <= '0;
    else        dat_sync_q <= {dat_sync_q[SYNC_STAGES-2:0], dat_in};
  end

  assign dat_s = dat_sync_q[SYNC_STAGES-1];

  i2s_rx_state_t     state_q;
  logic [CNT_W-1:0]  bit_cnt_q;
  logic [DATA_W-1:0] shreg_q;
  logic [DATA_W-1:0] left_q;
  logic [DATA_W-1:0] sample_l_q;
  logic [DATA_W-1:0] sample_r_q;
  logic [7:0]        wave_q;
  logic              valid_q;
  logic              overrun_q;
  logic [DATA_W-1:0] aligned_d;

  // A short word is moved up so its first bit lands in the MSB.
  assign aligned_d = shreg_q << (DATA_W_C - bit_cnt_q);

`ifdef I2S_RX_FRAME_CHECK_EN
  logic left_short_q;
  logic frame_err_q;
  logic chan_short_d;

  assign chan_short_d = (bit_cnt_q < DATA_W_C);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= WAIT_SYNC;
      bit_cnt_q  <= '0;
      shreg_q    <= '0;
      left_q     <= '0;
      sample_l_q <= '0;
      sample_r_q <= '0;
      wave_q     <= WAVE_OFFSET;
      valid_q    <= 1'b0;
      overrun_q  <= 1'b0;
`ifdef I2S_RX_FRAME_CHECK_EN
      left_short_q <= 1'b0;
      frame_err_q  <= 1'b0;
`endif
    end else begin
      // Accept first; a publish later in this block overrides it.
      if (valid_q && sample_ready) valid_q <= 1'b0;

      case (state_q)
        WAIT_SYNC: begin
          if (lrck_fall) begin
            state_q   <= DELAY;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
          end
        end
        DELAY, SHIFT: begin
          if (lrck_edge) begin
            state_q   <= DELAY;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
            if (lrck_rise) begin
              left_q <= aligned_d;
`ifdef I2S_RX_FRAME_CHECK_EN
              left_short_q <= chan_short_d;
`endif
            end else begin
              sample_l_q <= left_q;
              sample_r_q <= aligned_d;
              wave_q     <= left_q[DATA_W-1 -: 8] ^ WAVE_OFFSET;
              valid_q    <= 1'b1;
              if (valid_q && !sample_ready) overrun_q <= 1'b1;
`ifdef I2S_RX_FRAME_CHECK_EN
              frame_err_q <= left_short_q | chan_short_d;
`endif
            end
          end else if (bclk_rise) begin
            if (state_q == DELAY) begin
              state_q <= SHIFT;
            end else if (bit_cnt_q < DATA_W_C) begin
              shreg_q   <= {shreg_q[DATA_W-2:0], dat_s};
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end
          end
        end
        default: state_q <= WAIT_SYNC;
      endcase
    end
  end

  assign sample_l     = sample_l_q;
  assign sample_r     = sample_r_q;
  assign wave_out     = wave_q;
  assign sample_valid = valid_q;
  assign overrun      = overrun_q;

`ifdef I2S_RX_FRAME_CHECK_EN
  assign frame_err = frame_err_q;
`else
  assign frame_err = 1'b0;
`endif

endmodule

// File: tb/tb_i2s_receiver.sv
`timescale 1ns/1ps
module tb_i2s_receiver;

  localparam int HALF = 160;  // bclk half period: 8 clk cycles

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        bclk_in = 1'b0;
  logic        lrck_in = 1'b0;
  logic        dat_in = 1'b0;
  logic [15:0] sample_l;
  logic [15:0] sample_r;
  logic [7:0]  wave_out;
  logic        sample_valid;
  logic        sample_ready = 1'b1;
  logic        overrun;
  logic        frame_err;

  int checks = 0;
  int errors = 0;
  int valid_cycles = 0;
  int valid_rises = 0;
  logic valid_prev = 1'b0;
  int rises0;
  logic exp_short_err;

  i2s_receiver #(.DATA_W(16), .SYNC_STAGES(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bclk_in      (bclk_in),
    .lrck_in      (lrck_in),
    .dat_in       (dat_in),
    .sample_l     (sample_l),
    .sample_r     (sample_r),
    .wave_out     (wave_out),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .overrun      (overrun),
    .frame_err    (frame_err)
  );

  always #10 clk = ~clk;

  always @(negedge clk) begin
    if (!rst_n) begin
      valid_prev <= 1'b0;
    end else begin
      if (sample_valid) valid_cycles <= valid_cycles + 1;
      if (sample_valid && !valid_prev) valid_rises <= valid_rises + 1;
      valid_prev <= sample_valid;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // lrck edge + discarded slot bit, then nbits data bits MSB-first from word[31]
  task automatic send_chan(input logic lr, input logic [31:0] word, input int nbits);
    bclk_in = 1'b0; lrck_in = lr; dat_in = 1'b0; #(HALF);
    bclk_in = 1'b1; #(HALF);
    for (int i = 0; i < nbits; i++) begin
      bclk_in = 1'b0; dat_in = word[31-i]; #(HALF);
      bclk_in = 1'b1; #(HALF);
    end
  endtask

  // falling lrck closes the right channel
  task automatic close_pair();
    bclk_in = 1'b0; lrck_in = 1'b0; dat_in = 1'b0; #(HALF);
    repeat (4) @(negedge clk);
  endtask

  task automatic check_reset_values(input string pfx);
    check({pfx, "_sample_l"}, 32'(sample_l), 32'h0);
    check({pfx, "_sample_r"}, 32'(sample_r), 32'h0);
    check({pfx, "_wave_out"}, 32'(wave_out), 32'h80);
    check({pfx, "_valid"},    32'(sample_valid), 32'h0);
    check({pfx, "_overrun"},  32'(overrun), 32'h0);
    check({pfx, "_frame_err"}, 32'(frame_err), 32'h0);
  endtask

  initial begin
`ifdef I2S_RX_FRAME_CHECK_EN
    exp_short_err = 1'b1;
`else
    exp_short_err = 1'b0;
`endif
    // reset
    repeat (5) @(negedge clk);
    check_reset_values("rst");
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // stream starts mid right channel: must not publish
    sample_ready = 1'b1;
    send_chan(1'b1, 32'hDEAD_BEEF, 5);
    send_chan(1'b0, 32'h7F00_0000, 16);
    send_chan(1'b1, 32'h8001_0000, 16);
    check("no_pub_before_sync", 32'(valid_rises), 32'd0);
    close_pair();
    check("f1_rises", 32'(valid_rises), 32'd1);
    check("f1_pulse_len", 32'(valid_cycles), 32'd1);
    check("f1_sample_l", 32'(sample_l), 32'h7F00);
    check("f1_sample_r", 32'(sample_r), 32'h8001);
    check("f1_wave", 32'(wave_out), 32'hFF);
    check("f1_frame_err", 32'(frame_err), 32'h0);
    check("f1_valid_cleared", 32'(sample_valid), 32'h0);

    send_chan(1'b0, 32'h7F00_0000, 16);
    send_chan(1'b1, 32'h8001_0000, 16);
    close_pair();
    check("f2_rises", 32'(valid_rises), 32'd2);
    check("f2_pulse_len", 32'(valid_cycles), 32'd2);
    check("f2_sample_r", 32'(sample_r), 32'h8001);

    // 32-bit slots: extra bits ignored
    send_chan(1'b0, 32'h1234_ABCD, 32);
    send_chan(1'b1, 32'hFFFF_0000, 32);
    close_pair();
    check("s32_sample_l", 32'(sample_l), 32'h1234);
    check("s32_sample_r", 32'(sample_r), 32'hFFFF);
    check("s32_wave", 32'(wave_out), 32'h92);
    check("s32_frame_err", 32'(frame_err), 32'h0);

    // 12-bit channels: left-aligned, zero LSBs
    send_chan(1'b0, 32'hABC0_0000, 12);
    send_chan(1'b1, 32'h5A50_0000, 12);
    close_pair();
    check("s12_sample_l", 32'(sample_l), 32'hABC0);
    check("s12_sample_r", 32'(sample_r), 32'h5A50);
    check("s12_wave", 32'(wave_out), 32'h2B);
    check("s12_frame_err", 32'(frame_err), 32'(exp_short_err));

    // ready low: publish latency, then overrun on second pair
    sample_ready = 1'b0;
    send_chan(1'b0, 32'h1111_0000, 16);
    send_chan(1'b1, 32'h2222_0000, 16);
    @(posedge clk); #2;
    bclk_in = 1'b0; lrck_in = 1'b0; dat_in = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("lat_valid_early", 32'(sample_valid), 32'h0);
    @(posedge clk);
    @(negedge clk);
    check("lat_valid_on_time", 32'(sample_valid), 32'h1);
    repeat (8) @(negedge clk);
    check("hold_valid", 32'(sample_valid), 32'h1);
    check("hold_overrun", 32'(overrun), 32'h0);
    check("hold_sample_l", 32'(sample_l), 32'h1111);
    check("hold_frame_err", 32'(frame_err), 32'h0);
    send_chan(1'b0, 32'h3333_0000, 16);
    send_chan(1'b1, 32'h4444_0000, 16);
    close_pair();
    check("ovr_valid", 32'(sample_valid), 32'h1);
    check("ovr_sample_l", 32'(sample_l), 32'h3333);
    check("ovr_sample_r", 32'(sample_r), 32'h4444);
    check("ovr_flag", 32'(overrun), 32'h1);
    sample_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("ovr_valid_cleared", 32'(sample_valid), 32'h0);
    check("ovr_sticky", 32'(overrun), 32'h1);

    // reset after 7 bits of the left channel
    send_chan(1'b0, 32'hA5A5_0000, 7);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_values("midrst");
    rst_n = 1'b1;
    rises0 = valid_rises;
    send_chan(1'b0, 32'h5A00_0000, 8);
    send_chan(1'b1, 32'h9999_0000, 16);
    close_pair();
    check("midrst_no_pub_valid", 32'(sample_valid), 32'h0);
    check("midrst_no_pub_l", 32'(sample_l), 32'h0);
    send_chan(1'b0, 32'h0F0F_0000, 16);
    send_chan(1'b1, 32'hF0F0_0000, 16);
    close_pair();
    check("midrst_pub_rise", 32'(valid_rises), 32'(rises0 + 1));
    check("midrst_sample_l", 32'(sample_l), 32'h0F0F);
    check("midrst_sample_r", 32'(sample_r), 32'hF0F0);
    check("midrst_wave", 32'(wave_out), 32'h8F);
    check("midrst_overrun", 32'(overrun), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2s_receiver.md
# i2s_receiver

Receives the I2S serial stream from the WM8731 ADC path (ADCDAT with BCLK/ADCLRCK) and turns it into parallel stereo samples for the waveform display. It oversamples the serial pins in the 50 MHz `clk` domain and frames each left/right pair. It hands the pair to the capture buffer through a valid/ready handshake and also provides an unsigned 8-bit display sample. It is the receive counterpart of the I2S master transmitter feeding DACDAT.

## Interface
Parameters:
- `DATA_W`, default 16: bits captured per channel, MSB-first; legal range 8..32.
- `SYNC_STAGES`, default 2: flip-flop depth of the input synchronizers; minimum 2.

Ports:
- `clk`, input, 1: system clock, 50 MHz.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `bclk_in`, input, 1: I2S bit clock, asynchronous to `clk`; must satisfy f ≤ f_clk/8.
- `lrck_in`, input, 1: word clock; low selects the left channel, high selects the right channel.
- `dat_in`, input, 1: serial data, valid on rising `bclk_in`.
- `sample_l`, output, DATA_W: last completed left word, two's complement.
- `sample_r`, output, DATA_W: last completed right word, two's complement.
- `wave_out`, output, 8: `sample_l[DATA_W-1 -: 8] ^ 8'h80`, offset-binary value for display.
- `sample_valid`, output, 1: a new pair is held on the outputs.
- `sample_ready`, input, 1: the consumer accepts the pair.
- `overrun`, output, 1: sticky flag; a pair completed while the previous pair was not yet accepted.
- `frame_err`, output, 1: the current pair had a short channel. Qualified by `sample_valid`.

## Operation
- All three pins pass through `SYNC_STAGES` flops each. Edge detection compares the last synchronizer stage with a one-flop delayed copy.
- The receive state machine has three states: WAIT_SYNC, DELAY, SHIFT.
- WAIT_SYNC: entered on reset. Every bclk and lrck edge is ignored until the first synchronized falling edge of lrck. That edge moves the machine to DELAY for the left channel.
- DELAY: the first rising edge of bclk after an lrck edge is the I2S one-bit slot and is discarded. The machine then moves to SHIFT.
- SHIFT: on each rising edge of bclk, while `bit_cnt < DATA_W`, the machine shifts `dat` into the channel shift register and increments `bit_cnt`. Extra bit clocks in the slot (for example 32-bit slots) are ignored.
- Any lrck edge while in SHIFT closes the current channel.
- A short channel (`bit_cnt < DATA_W`) is left-aligned with zero LSBs. The machine then returns to DELAY and resets `bit_cnt` to 0.
- Left closes on the rising edge of lrck. Right closes on the falling edge of lrck; that edge publishes the pair.
- Publish: the machine loads `sample_l`, `sample_r`, `wave_out` and `frame_err`, then sets `sample_valid`.
  - If `sample_valid` is already set and `sample_ready` is low in the publish cycle, `overrun` is set and the new data overwrites the old.
- Handshake: `sample_valid` clears on the cycle after `sample_valid && sample_ready`.
  - If a publish and an accept happen in the same cycle, the publish wins: `sample_valid` stays 1 with the new data and `overrun` is not set.
- `overrun` clears only on reset.
- Reset mid-frame: all state is discarded and the machine returns to WAIT_SYNC. The partial frame is never published.

## Timing
- Reset values: `sample_l` = 0, `sample_r` = 0, `wave_out` = 8'h80, `sample_valid` = 0, `overrun` = 0, `frame_err` = 0. All synchronizer and shift flops are 0; state is WAIT_SYNC.
- Edge detect: a pin edge is seen `SYNC_STAGES`+1 clk cycles after it occurs.
- `sample_valid` rises `SYNC_STAGES`+2 clk cycles after the falling edge of `lrck_in` that closes the right channel.
- `dat` is taken in the same clk cycle as the detected bclk rising edge. Both pass through equal synchronizer depth, so the relative skew is preserved.
- Throughput: one pair per lrck period. The consumer has the full lrck period (about 1042 clk at 48 kHz) to assert `sample_ready`.

## Configuration
- `I2S_RX_FRAME_CHECK_EN` defined:
  - The block counts bits per channel.
  - `frame_err` = 1 when either channel of the published pair had `bit_cnt < DATA_W`, or when an lrck edge arrived while still in DELAY.
- Macro undefined:
  - The counting logic is removed and `frame_err` is tied to 0.
  - The zero-padding of short words still applies.

## Structure
- Package `i2s_pkg`:
  - `i2s_rx_state_t` enum (WAIT_SYNC, DELAY, SHIFT).
  - `I2S_DATA_W_DEF` = 16.
  - `WAVE_OFFSET` = 8'h80.
  - The transmitter uses the same package.
- Sub-module `i2s_sync_edge`:
  - An N-stage synchronizer plus rise/fall pulse outputs.
  - Instantiated for bclk and lrck.
  - `dat` uses the synchronizer only.

## Test plan
- Reset, then 48 kHz frames with 16 bclk per channel, L = 16'h7F00, R = 16'h8001, `sample_ready` held high: `sample_l` = 7F00, `sample_r` = 8001, `wave_out` = 8'hFF, one-cycle `sample_valid` pulse per frame, `frame_err` = 0.
- Frame stream starts while `lrck_in` is already high, mid right channel: nothing is published until after the first falling edge of lrck plus one complete frame.
- 32 bclk per channel, L = 32'h1234_ABCD, `DATA_W` = 16: `sample_l` = 16'h1234.
- 12 bclk per channel with `I2S_RX_FRAME_CHECK_EN` defined, L data 12'hABC: `sample_l` = 16'hABC0, `frame_err` = 1. With the macro undefined: `frame_err` = 0.
- `sample_ready` held low across two frames: `sample_valid` stays 1, the outputs show the second pair, and `overrun` = 1 and stays 1 after ready returns.
- `rst_n` pulsed after 7 bits of the left channel: all outputs return to reset values, and the next pair is published only after a full frame following a new falling edge of lrck.
